mesh_ctrl: RTL and testbench

MESH_CTRL -- requirements
Module: mesh_ctrl

---
 rtl/mesh_ctrl_if.sv | 23 ++
 rtl/mesh_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mesh_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesh_ctrl_if.sv
// Weight-stream and tile-broadcast bundle between the mesh controller and its environment.
// The slave modport is the controller's side; the master modport is the feeder/tile side.
interface mesh_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;

  modport master (
    output w_data, w_valid,
    input  w_ready, cfg_addr, cfg_data, cfg_valid
  );

  modport slave (
    input  w_data, w_valid,
    output w_ready, cfg_addr, cfg_data, cfg_valid
  );
endinterface

// File: rtl/mesh_ctrl.sv
// Mesh load/compute sequencer: streams weights row-major into tile config, then
// steps the tiles through LOAD_X and MAC phases and pulses done.
module mesh_ctrl #(
  parameter int DW      = 8,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 4,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int X_CYC   = 4,
  parameter int MAC_CYC = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  mesh_ctrl_if.slave  bus,
  output logic [1:0]  global_state,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  localparam int AW   = ROW_W + COL_W;
  localparam int MX1  = (ROWS * COLS > X_CYC) ? ROWS * COLS : X_CYC;
  localparam int MAXC = (MX1 > MAC_CYC) ? MX1 : MAC_CYC;
  localparam int PW   = $clog2(MAXC + 1);

  localparam logic [1:0] GS_LOAD_W = 2'd0;
  localparam logic [1:0] GS_LOAD_X = 2'd1;
  localparam logic [1:0] GS_MAC    = 2'd2;
  localparam logic [1:0] GS_IDLE   = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    W_DRAIN = 3'd2,
    LOAD_X  = 3'd3,
    MAC     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [PW-1:0]    cnt_q;
  logic             w_ready_q;
  logic             cfg_valid_q;
  logic [AW-1:0]    cfg_addr_q;
  logic [DW-1:0]    cfg_data_q;
  logic [1:0]       gs_q;
  logic             busy_q;
  logic             done_q;

  logic last_beat;
  logic col_last;
  logic accept;

  // Handshake: a weight beat transfers on a rising edge where w_valid && w_ready;
  // w_ready is registered and high only while the FSM sits in LOAD_W.
  assign col_last  = (col_q == COL_W'(COLS - 1));
  assign last_beat = col_last && (row_q == ROW_W'(ROWS - 1));
  assign accept    = bus.w_valid && w_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      w_ready_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      gs_q        <= GS_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        w_ready_q <= 1'b0;
        gs_q      <= GS_IDLE;
        busy_q    <= 1'b0;
        cnt_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q   <= LOAD_W;
              row_q     <= '0;
              col_q     <= '0;
              cnt_q     <= '0;
              w_ready_q <= 1'b1;
              gs_q      <= GS_LOAD_W;
              busy_q    <= 1'b1;
            end
          end

          LOAD_W: begin
            if (accept) begin
              cfg_valid_q <= 1'b1;
              cfg_addr_q  <= {row_q, col_q};
              cfg_data_q  <= bus.w_data;
              if (last_beat) begin
                state_q   <= W_DRAIN;
                w_ready_q <= 1'b0;
              end else if (col_last) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
              end else begin
                col_q <= col_q + COL_W'(1);
              end
            end
          end

          // The final beat is still on the broadcast bus here, so tiles stay in LOAD_W.
          W_DRAIN: begin
            state_q <= LOAD_X;
            gs_q    <= GS_LOAD_X;
            cnt_q   <= '0;
          end

          LOAD_X: begin
            if (cnt_q == PW'(X_CYC - 1)) begin
              state_q <= MAC;
              gs_q    <= GS_MAC;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + PW'(1);
            end
          end

          MAC: begin
            if (cnt_q == PW'(MAC_CYC - 1)) begin
              state_q <= DONE;
              gs_q    <= GS_IDLE;
              done_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + PW'(1);
            end
          end

          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end

          default: begin
            state_q   <= IDLE;
            w_ready_q <= 1'b0;
            gs_q      <= GS_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
          end
        endcase
      end
    end
  end

  assign bus.w_ready   = w_ready_q;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.cfg_addr  = cfg_addr_q;
  assign bus.cfg_data  = cfg_data_q;
  assign global_state  = gs_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mesh_ctrl.sv
// Directed bench for mesh_ctrl: a default 4x4 instance and a 2x3 instance with
// single-cycle phases, cfg broadcasts checked against an expected queue.
module tb_mesh_ctrl;
  localparam int DW = 8;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int AW = ROW_W + COL_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mesh_ctrl_if #(.DW(DW), .AW(AW)) bus_a();
  mesh_ctrl_if #(.DW(DW), .AW(AW)) bus_b();

  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [1:0] gs_a, gs_b;
  logic busy_a, busy_b, done_a, done_b;
  logic [2:0] dbg_a, dbg_b;

  mesh_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .bus(bus_a.slave),
    .global_state(gs_a), .busy(busy_a), .done(done_a), .dbg_state(dbg_a)
  );

  mesh_ctrl #(.ROWS(2), .COLS(3), .X_CYC(1), .MAC_CYC(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .bus(bus_b.slave),
    .global_state(gs_b), .busy(busy_b), .done(done_b), .dbg_state(dbg_b)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [AW+DW-1:0] exp_a[$];
  logic [AW+DW-1:0] exp_b[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst_n && bus_a.cfg_valid) begin
      if (exp_a.size() == 0) begin
        check("cfg_a_extra", {bus_a.cfg_addr, bus_a.cfg_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_a.pop_front();
        check("cfg_a", {bus_a.cfg_addr, bus_a.cfg_data}, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst_n && bus_b.cfg_valid) begin
      if (exp_b.size() == 0) begin
        check("cfg_b_extra", {bus_b.cfg_addr, bus_b.cfg_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_b.pop_front();
        check("cfg_b", {bus_b.cfg_addr, bus_b.cfg_data}, e);
      end
    end
  end

  // accessors
  function automatic logic [1:0] gs_of(input bit sel);
    return sel ? gs_b : gs_a;
  endfunction
  function automatic logic done_of(input bit sel);
    return sel ? done_b : done_a;
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic wr_of(input bit sel);
    return sel ? bus_b.w_ready : bus_a.w_ready;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_w(input bit sel, input logic v, input logic [DW-1:0] d);
    if (sel) begin bus_b.w_valid = v; bus_b.w_data = d; end
    else begin bus_a.w_valid = v; bus_a.w_data = d; end
  endtask

  task automatic drive_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  function automatic logic [AW-1:0] exp_addr(input bit sel, input int k);
    int cols;
    cols = sel ? 3 : 4;
    return {ROW_W'(k / cols), COL_W'(k % cols)};
  endfunction

  task automatic feed(input bit sel, input int n, input bit gap, input int base);
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = DW'(base + k);
      if (sel) exp_b.push_back({exp_addr(sel, k), d});
      else     exp_a.push_back({exp_addr(sel, k), d});
      drive_w(sel, 1'b1, d);
      tick();
      if (gap) begin
        drive_w(sel, 1'b0, d);
        tick();
      end
    end
    drive_w(sel, 1'b0, '0);
  endtask

  task automatic issue_start(input bit sel);
    tick();
    drive_start(sel, 1'b1);
    tick();
    drive_start(sel, 1'b0);
  endtask

  // Counts edges from the start-sampling edge until done is seen.
  task automatic watch(input bit sel, input int exp_edges, input int e0, input int e1, input int e2);
    int n, c0, c1, c2;
    bit seen;
    n = 0; c0 = 0; c1 = 0; c2 = 0; seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_of(sel)) begin
        seen = 1;
        break;
      end
      case (gs_of(sel))
        2'd0: c0++;
        2'd1: c1++;
        2'd2: c2++;
        default: ;
      endcase
      @(posedge clk);
      n++;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("done_edge", n, exp_edges);
    check("cycles_gs0", c0, e0);
    check("cycles_gs1", c1, e1);
    check("cycles_gs2", c2, e2);
    check("done_cycle_gs_busy", {gs_of(sel), busy_of(sel)}, {2'd3, 1'b1});
    @(negedge clk);
    check("post_done", {done_of(sel), busy_of(sel), gs_of(sel), wr_of(sel)}, {1'b0, 1'b0, 2'd3, 1'b0});
  endtask

  task automatic poke_start(input bit sel);
    for (logic [1:0] g = 2'd1; g <= 2'd2; g++) begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (gs_of(sel) == g) begin hit = 1; break; end
      end
      check("poke_reach_phase", 32'(hit), 32'd1);
      tick();
      drive_start(sel, 1'b1);
      tick();
      drive_start(sel, 1'b0);
      if (g == 2'd2) break;
    end
  endtask

  task automatic run_pass(input bit sel, input int beats, input bit gap, input int base,
                          input int exp_edges, input int e0, input int e1, input int e2,
                          input bit poke);
    issue_start(sel);
    fork
      feed(sel, beats, gap, base);
      watch(sel, exp_edges, e0, e1, e2);
      begin
        if (poke) poke_start(sel);
      end
    join
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"}, {gs_a, bus_a.cfg_addr, bus_a.cfg_data, bus_a.cfg_valid, bus_a.w_ready, busy_a, done_a},
          {2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    check({tag, "_b"}, {gs_b, bus_b.cfg_addr, bus_b.cfg_data, bus_b.cfg_valid, bus_b.w_ready, busy_b, done_b},
          {2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    bit hit;
    bus_a.w_valid = 1'b0; bus_a.w_data = '0;
    bus_b.w_valid = 1'b0; bus_b.w_data = '0;
    #12;
    check_reset_outputs("reset_state");
    tick();
    rst_n = 1'b1;
    tick();

    // full back-to-back pass: 16 LOAD_W + drain, 4 LOAD_X, 7 MAC, done 28 edges after start
    run_pass(1'b0, 16, 1'b0, 1, 28, 17, 4, 7, 1'b0);
    // w_valid alternating: beats on every other edge, last at edge 31
    run_pass(1'b0, 16, 1'b1, 8'h11, 43, 32, 4, 7, 1'b0);
    // start pulses inside LOAD_X and MAC must not disturb timing
    run_pass(1'b0, 16, 1'b0, 8'h31, 28, 17, 4, 7, 1'b1);

    // abort together with beat 5
    issue_start(1'b0);
    feed(1'b0, 5, 1'b0, 8'h40);
    drive_w(1'b0, 1'b1, 8'h45);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    drive_w(1'b0, 1'b0, '0);
    @(negedge clk);
    check("after_abort", {gs_a, bus_a.w_ready, busy_a, bus_a.cfg_valid, done_a}, {2'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    check("abort_queue_empty", exp_a.size(), 0);
    repeat (3) tick();
    check("abort_stays_idle", {gs_a, busy_a}, {2'd3, 1'b0});
    run_pass(1'b0, 16, 1'b0, 8'h50, 28, 17, 4, 7, 1'b0);

    // reset asserted during MAC
    issue_start(1'b0);
    feed(1'b0, 16, 1'b0, 8'h80);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gs_a == 2'd2) begin hit = 1; break; end
    end
    check("reach_mac", 32'(hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle_after_reset", {gs_a, busy_a, bus_a.cfg_valid, bus_a.w_ready, done_a}, {2'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    end

    // 2x3 mesh, single-cycle phases: done 9 edges after start edge
    run_pass(1'b1, 6, 1'b0, 8'h21, 9, 7, 1, 1, 1'b0);

    repeat (3) tick();
    check("queue_a_drained", exp_a.size(), 0);
    check("queue_b_drained", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
